mprj_io_cfg_loader: RTL and testbench
=====================================

MPRJ_IO_CFG_LOADER -- requirements
Module: mprj_io_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_PADS, default 38, number of user pads in the serial configuration chain.
REQ-002 SHALL have parameter CFG_BITS, default 13, configuration bits per pad.
REQ-003 SHALL have parameter CLK_DIV, default 2 (legal 1..255), clock cycles per serial_clock phase.
REQ-004 SHALL have parameter CFG_RESET, default 13'h0403, per-pad configuration value after reset.
REQ-005 SHALL have port clock, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port cfg_we, input, 1, per-pad configuration write strobe.
REQ-008 SHALL have port cfg_addr, input, clog2(NUM_PADS), pad index for writes and reads.
REQ-009 SHALL have port cfg_wdata, input, CFG_BITS, write data.
REQ-010 SHALL have port cfg_rdata, output, CFG_BITS, combinational read of entry cfg_addr.
REQ-011 SHALL have port start, input, 1, single-cycle request to shift the chain.
REQ-012 SHALL have port busy, output, 1, transfer in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at the end of a transfer.
REQ-014 SHALL have port wr_err, output, 1, one-cycle pulse when a write is rejected.
REQ-015 SHALL have ports serial_clock, serial_data_out, serial_load, outputs, 1 each, driving the pad control chain.
REQ-016 SHALL have port serial_data_in, input, 1, chain return (used only when READBACK_EN is defined).

Function
REQ-017 SHALL hold NUM_PADS registers of CFG_BITS bits; cfg_we with busy low writes cfg_wdata to entry cfg_addr on the next edge.
REQ-018 SHALL reject cfg_we while busy or with cfg_addr >= NUM_PADS (no entry changes) and pulse wr_err in the following cycle.
REQ-019 SHALL use states IDLE, SHIFT, LOAD, DONE; start in IDLE moves to SHIFT, and busy rises in the next cycle.
REQ-020 SHALL ignore start outside IDLE, with no queuing and no error.
REQ-021 SHALL shift NUM_PADS*CFG_BITS bits, pad NUM_PADS-1 first and MSB first within each pad, so that pad 0 LSB is shifted last.
REQ-022 SHALL present each bit on serial_data_out for CLK_DIV cycles with serial_clock low, then CLK_DIV cycles with serial_clock high, with data stable across the rising serial_clock edge.
REQ-023 SHALL move from SHIFT to LOAD after the final high phase, then drive serial_load high for CLK_DIV cycles with serial_clock low.
REQ-024 SHALL go from LOAD to DONE for one cycle, pulse done, drop busy, and return to IDLE.
REQ-025 Total transfer latency from the start edge to the done pulse SHALL be 2*CLK_DIV*NUM_PADS*CFG_BITS + CLK_DIV + 2 cycles.
REQ-026 SHALL use a bit counter of clog2(NUM_PADS*CFG_BITS+1) bits and a phase counter of 8 bits, with no wrap beyond the terminal count.
REQ-027 SHALL take a snapshot of the register contents at start, so that values shifted out equal the contents at start.

Reset
REQ-028 resetn low SHALL asynchronously force IDLE and set every entry to CFG_RESET, serial_clock, serial_data_out, serial_load, busy, done, wr_err and counters to 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no serial_load pulse and no done pulse; deassertion SHALL return to IDLE.

Configuration
REQ-030 With READBACK_EN defined, SHALL sample serial_data_in on each rising serial_clock during the second half of the bit stream and compare it against the bits shifted in the first half, setting sticky output rb_err (1 bit, cleared by start or reset).
REQ-031 Without READBACK_EN, rb_err and the comparison logic SHALL be absent and serial_data_in SHALL be unused.

Verification
REQ-032 Reset with no writes, then start -> 494 bits of pattern 13'h0403 per pad; done exactly at cycle 2*2*494+4 = 1980 after start.
REQ-033 Write pad 0 = 13'h1FFF, pad 37 = 13'h0001, then start -> first 13 bits shifted are 0000000000001 and the last 13 are all 1; serial_load high for 2 cycles.
REQ-034 Write pad 5 while busy, or write to cfg_addr = 40 -> wr_err pulses for 1 cycle, cfg_rdata unchanged.
REQ-035 Assert resetn low at bit 100 -> all outputs 0 immediately, no done pulse, cfg_rdata of every pad = 13'h0403.
REQ-036 Pulse start twice during SHIFT -> only one transfer, and exactly one done pulse.
REQ-037 With READBACK_EN defined, loop serial_data_out to serial_data_in through a 494-bit delay model -> rb_err = 0; flip one returned bit -> rb_err = 1.

Source files
------------

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader
//   Holds one CFG_BITS-wide configuration word per user pad and, on request,
//   shifts the whole set out through the serial pad-control chain. The
//   transfer is followed by a serial_load strobe and a one-cycle done pulse.
//
// Ports
//   clock, resetn            : single rising-edge clock, async active-low reset
//   cfg_we/cfg_addr/wdata    : per-pad write port (rejected while busy or out of range)
//   cfg_rdata                : combinational read of entry cfg_addr (0 when out of range)
//   start                    : one-cycle request to shift the chain (ignored unless idle)
//   busy, done, wr_err       : transfer status, end-of-transfer pulse, rejected-write pulse
//   serial_clock/data_out/load : pad chain drive
//   serial_data_in           : chain return, used only with READBACK_EN
//   rb_err                   : sticky readback mismatch (only with READBACK_EN)
//
// Optional feature macro: READBACK_EN
module mprj_io_cfg_loader #(
  parameter int                  NUM_PADS  = 38,
  parameter int                  CFG_BITS  = 13,
  parameter int                  CLK_DIV   = 2,
  parameter logic [CFG_BITS-1:0] CFG_RESET = 13'h0403
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_PADS)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]         cfg_wdata,
  output logic [CFG_BITS-1:0]         cfg_rdata,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        wr_err,
  output logic                        serial_clock,
  output logic                        serial_data_out,
  output logic                        serial_load,
  input  logic                        serial_data_in
`ifdef READBACK_EN
  ,
  output logic                        rb_err
`endif
);

  localparam int AW  = $clog2(NUM_PADS);
  localparam int TOT = NUM_PADS * CFG_BITS;
  localparam int BW  = $clog2(TOT + 1);
  localparam logic [AW:0]   NP       = (AW + 1)'(NUM_PADS);
  localparam logic [7:0]    PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TOT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
`ifdef READBACK_EN
  localparam int            HALF     = TOT / 2;
  localparam logic [BW-1:0] HALF_IDX = BW'(HALF);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] cfg_q [NUM_PADS];
  logic [TOT-1:0]      sr_q, sr_d;
  logic [TOT-1:0]      flat;
  logic [7:0]          ph_q, ph_d;
  logic                half_q, half_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_err_q, wr_err_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                sload_q, sload_d;
  logic                addr_ok;
  logic                wr_ok;
`ifdef READBACK_EN
  logic                rb_err_q, rb_err_d;
`else
  logic                unused_sdi;
  assign unused_sdi = serial_data_in;
`endif

  assign addr_ok = ({1'b0, cfg_addr} < NP);
  // The state check closes the one-cycle window after start where busy is still low.
  assign wr_ok   = cfg_we && addr_ok && !busy_q && (state_q == IDLE);

  assign cfg_rdata       = addr_ok ? cfg_q[cfg_addr] : '0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign wr_err          = wr_err_q;
  assign serial_clock    = sclk_q;
  assign serial_data_out = sdo_q;
  assign serial_load     = sload_q;
`ifdef READBACK_EN
  assign rb_err          = rb_err_q;
`endif

  // Pack the register file so pad NUM_PADS-1's MSB lands at the top of the shifter.
  always_comb begin
    flat = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      flat[p*CFG_BITS +: CFG_BITS] = cfg_q[p];
    end
  end

  // Per-pad configuration register file.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        cfg_q[i] <= CFG_RESET;
      end
    end else if (wr_ok) begin
      cfg_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Next-state, counters and registered-output values; outputs follow state by one cycle.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    ph_d     = ph_q;
    half_d   = half_q;
    bit_d    = bit_q;
    busy_d   = (state_q == SHIFT) || (state_q == LOAD);
    done_d   = (state_q == DONE);
    wr_err_d = cfg_we && !wr_ok;
    sclk_d   = (state_q == SHIFT) && half_q;
    sdo_d    = (state_q == SHIFT) ? sr_q[TOT-1] : 1'b0;
    sload_d  = (state_q == LOAD);
`ifdef READBACK_EN
    rb_err_d = rb_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = flat;
          ph_d    = 8'd0;
          half_d  = 1'b0;
          bit_d   = '0;
`ifdef READBACK_EN
          rb_err_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef READBACK_EN
        // Sample on the rising serial_clock edge. The shifter rotates, so the
        // bit sent HALF positions earlier now sits at index HALF-1.
        if (half_q && (ph_q == 8'd0) && (bit_q >= HALF_IDX) &&
            (serial_data_in != sr_q[HALF-1])) begin
          rb_err_d = 1'b1;
        end else begin
          rb_err_d = rb_err_q;
        end
`endif
        if (ph_q == PH_LAST) begin
          ph_d = 8'd0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            sr_d   = {sr_q[TOT-2:0], sr_q[TOT-1]};
            if (bit_q == BIT_LAST) begin
              state_d = LOAD;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      LOAD: begin
        if (ph_q == PH_LAST) begin
          ph_d    = 8'd0;
          state_d = DONE;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      ph_q     <= 8'd0;
      half_q   <= 1'b0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
      sload_q  <= 1'b0;
`ifdef READBACK_EN
      rb_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      ph_q     <= ph_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      sload_q  <= sload_d;
`ifdef READBACK_EN
      rb_err_q <= rb_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Self-checking bench for mprj_io_cfg_loader (default parameters).
module tb_mprj_io_cfg_loader;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = 6'd0;
  logic [12:0] cfg_wdata = 13'd0;
  logic [12:0] cfg_rdata;
  logic        start = 1'b0;
  logic        busy, done, wr_err;
  logic        serial_clock, serial_data_out, serial_load;
  logic        serial_data_in = 1'b0;
`ifdef READBACK_EN
  logic        rb_err;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] exp_cfg [38];
  logic        sb [$];

  mprj_io_cfg_loader dut (
    .clock           (clock),
    .resetn          (resetn),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_rdata       (cfg_rdata),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .wr_err          (wr_err),
    .serial_clock    (serial_clock),
    .serial_data_out (serial_data_out),
    .serial_load     (serial_load),
    .serial_data_in  (serial_data_in)
`ifdef READBACK_EN
    ,
    .rb_err          (rb_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pads();
    for (int p = 0; p < 38; p++) begin
      cfg_addr = 6'(p);
      #1;
      check("rdata", 32'(cfg_rdata), 32'(exp_cfg[p]));
    end
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [12:0] d, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    check("wr_err", 32'(wr_err), 32'(exp_err));
    if (!exp_err) exp_cfg[a] = d;
    @(posedge clock); #1;
    check("wr_err_clr", 32'(wr_err), 32'd0);
  endtask

  // One transfer. wr_at: cycle of a write attempt while busy; dup1/dup2: extra
  // start pulses; rst_bit: assert reset after that many serial bits (0 = none).
  task automatic run_xfer(input int wr_at, input int dup1, input int dup2, input int rst_bit);
    int   cyc, dones, loads, nbits, done_cyc, busy_cnt;
    logic prev, e;
    for (int p = 37; p >= 0; p--)
      for (int b = 12; b >= 0; b--)
        sb.push_back(exp_cfg[p][b]);
    cyc = 0; dones = 0; loads = 0; nbits = 0; done_cyc = -1; prev = 1'b0;
    start = 1'b1;
    while (cyc < 2100) begin
      @(posedge clock); #1;
      cyc++;
      start = (cyc == dup1) || (cyc == dup2);
      if (cyc == 2) check("busy_rise", 32'(busy), 32'd1);
      if (wr_at > 0) begin
        if (cyc == wr_at) begin
          cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 13'h0AAA;
        end else if (cyc == wr_at + 1) begin
          cfg_we = 1'b0;
          check("busy_wr_err", 32'(wr_err), 32'd1);
        end else if (cyc == wr_at + 2) begin
          check("busy_wr_err_clr", 32'(wr_err), 32'd0);
        end
      end
      if (serial_clock && !prev) begin
        nbits++;
        if (sb.size() == 0) begin
          check("bit_count", 32'(nbits), 32'd494);
        end else begin
          e = sb.pop_front();
          check("bit", 32'(serial_data_out), 32'(e));
        end
      end
      prev = serial_clock;
      if (serial_load) loads++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rst_bit > 0 && nbits == rst_bit) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 30) break;
    end
    if (rst_bit > 0) begin
      check("rst_bit_reached", 32'(nbits), 32'(rst_bit));
      resetn = 1'b0;
      #1;
      check("rst_outs", 32'({serial_clock, serial_data_out, serial_load, busy, done, wr_err}), 32'd0);
      for (int p = 0; p < 38; p++) exp_cfg[p] = 13'h0403;
      check_pads();
      sb.delete();
      @(negedge clock);
      resetn = 1'b1;
      dones = 0; loads = 0; busy_cnt = 0;
      repeat (2500) begin
        @(posedge clock); #1;
        if (done) dones++;
        if (serial_load) loads++;
        if (busy) busy_cnt++;
      end
      check("abort_done", 32'(dones), 32'd0);
      check("abort_load", 32'(loads), 32'd0);
      check("abort_busy", 32'(busy_cnt), 32'd0);
    end else begin
      check("done_count", 32'(dones), 32'd1);
      check("done_latency", 32'(done_cyc), 32'd1980);
      check("load_cycles", 32'(loads), 32'd2);
      check("bits_left", 32'(sb.size()), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    for (int p = 0; p < 38; p++) exp_cfg[p] = 13'h0403;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", 32'({serial_clock, serial_data_out, serial_load, busy, done, wr_err}), 32'd0);
    check_pads();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Reset contents shifted out, latency and load width.
    run_xfer(0, 0, 0, 0);

    // Distinct end pads to check ordering.
    cfg_write(6'd0, 13'h1FFF, 1'b0);
    cfg_write(6'd37, 13'h0001, 1'b0);
    cfg_write(6'd12, 13'h0A5C, 1'b0);
    check_pads();
    run_xfer(0, 0, 0, 0);

    // Out-of-range address rejected.
    cfg_write(6'd40, 13'h1555, 1'b1);
    check_pads();

    // Write while busy and repeated start pulses during SHIFT.
    run_xfer(10, 50, 700, 0);
    check_pads();

    // Reset mid-transfer.
    cfg_write(6'd5, 13'h1234, 1'b0);
    run_xfer(0, 0, 0, 100);
    check_pads();

    // Normal operation after the abort.
    cfg_write(6'd20, 13'h0F0F, 1'b0);
    run_xfer(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
